joy_decoder: RTL and testbench

JOY_DECODER -- requirements
Module: joy_decoder

---
 rtl/joy_pkg.sv | 44 ++++
 rtl/joy_axis.sv | 106 ++++++++++
 rtl/joy_decoder.sv | 130 +++++++++++++
 tb/tb_joy_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Purpose : shared types and constants for the joystick decoder slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: axis-state enum, poll FSM enum, DOUT field bit positions,
// default threshold constants and field-extraction helpers.
package joy_pkg;

   typedef enum logic [1:0] {
      AX_CENTER = 2'd0,
      AX_POS    = 2'd1,
      AX_NEG    = 2'd2
   } axis_state_t;

   typedef enum logic [1:0] {
      ST_REQ    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2
   } fsm_state_t;

   // DOUT packet layout: each axis is split into a low byte and a 2-bit MSB field
   localparam int X_LO_MSB = 39;
   localparam int X_LO_LSB = 32;
   localparam int X_HI_MSB = 25;
   localparam int X_HI_LSB = 24;
   localparam int Y_LO_MSB = 23;
   localparam int Y_LO_LSB = 16;
   localparam int Y_HI_MSB = 9;
   localparam int Y_HI_LSB = 8;
   localparam int BTN_BIT  = 0;

   localparam int DEF_HI_THR = 700;
   localparam int DEF_LO_THR = 324;
   localparam int DEF_HYST   = 32;

   function automatic logic [9:0] get_x(input logic [39:0] d);
      return {d[X_HI_MSB:X_HI_LSB], d[X_LO_MSB:X_LO_LSB]};
   endfunction

   function automatic logic [9:0] get_y(input logic [39:0] d);
      return {d[Y_HI_MSB:Y_HI_LSB], d[Y_LO_MSB:Y_LO_LSB]};
   endfunction

endpackage

// File: rtl/joy_axis.sv
// Purpose : one joystick axis - CENTER/POS/NEG tracking with hysteresis, entry (and optional repeat) pulses.
// Latency : pulses appear the cycle after the sample strobe; one cycle wide.
// Backpressure: none; a pulse is produced for every qualifying sample strobe.
//
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   sample_en  one-cycle strobe: val is a new sample
//   init       first sample after reset: update state, suppress pulses
//   val        unsigned 10-bit axis value
//   pos_pulse  pulse on entering (or auto-repeating) POS
//   neg_pulse  pulse on entering (or auto-repeating) NEG
// Optional feature: define JOY_AUTOREPEAT_EN to re-pulse a held deflection.
module joy_axis
   import joy_pkg::*;
#(
   parameter int HI_THR   = DEF_HI_THR,
   parameter int LO_THR   = DEF_LO_THR,
   parameter int HYST     = DEF_HYST,
   parameter int REP_DLY  = 50,
   parameter int REP_RATE = 10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       sample_en,
   input  logic       init,
   input  logic [9:0] val,
   output logic       pos_pulse,
   output logic       neg_pulse
);

   localparam logic [9:0] HI_V    = 10'(HI_THR);
   localparam logic [9:0] LO_V    = 10'(LO_THR);
   localparam logic [9:0] HI_EXIT = 10'(HI_THR - HYST);
   localparam logic [9:0] LO_EXIT = 10'(LO_THR + HYST);

   axis_state_t st;
   axis_state_t st_nxt;
   logic        enter;
   logic        rep_fire;

   // Entry uses the strict thresholds from any state, so POS<->NEG is direct;
   // leaving back to CENTER needs the value to cross the hysteresis margin.
   always_comb begin
      st_nxt = st;
      case (st)
         AX_CENTER: begin
            if (val > HI_V)      st_nxt = AX_POS;
            else if (val < LO_V) st_nxt = AX_NEG;
         end
         AX_POS: begin
            if (val < LO_V)         st_nxt = AX_NEG;
            else if (val < HI_EXIT) st_nxt = AX_CENTER;
         end
         AX_NEG: begin
            if (val > HI_V)         st_nxt = AX_POS;
            else if (val > LO_EXIT) st_nxt = AX_CENTER;
         end
         default: st_nxt = AX_CENTER;
      endcase
   end

   assign enter = (st_nxt != AX_CENTER) && (st_nxt != st);

`ifdef JOY_AUTOREPEAT_EN
   localparam logic [15:0] REP_DLY_V  = 16'(REP_DLY);
   localparam logic [15:0] REP_RATE_V = 16'(REP_RATE);

   // Down-counter of samples until the next repeat; reaching 1 on a held
   // sample fires and reloads with the repeat rate.
   logic [15:0] rcnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rcnt <= '0;
      end else if (sample_en) begin
         if (st_nxt == AX_CENTER)  rcnt <= '0;
         else if (enter)           rcnt <= REP_DLY_V;
         else if (rcnt == 16'd1)   rcnt <= REP_RATE_V;
         else if (rcnt != 16'd0)   rcnt <= rcnt - 16'd1;
      end
   end

   assign rep_fire = !enter && (st_nxt != AX_CENTER) && (rcnt == 16'd1);
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         st        <= AX_CENTER;
         pos_pulse <= 1'b0;
         neg_pulse <= 1'b0;
      end else begin
         pos_pulse <= 1'b0;
         neg_pulse <= 1'b0;
         if (sample_en) begin
            st <= st_nxt;
            if (!init) begin
               pos_pulse <= (st_nxt == AX_POS) && (enter || rep_fire);
               neg_pulse <= (st_nxt == AX_NEG) && (enter || rep_fire);
            end
         end
      end
   end

endmodule

// File: rtl/joy_decoder.sv
// Purpose : polls a joystick SPI front end and turns samples into position and direction/button pulses.
// Latency : outputs update one cycle after the SAMPLE state; SND_REC lags the REQ state by one cycle.
// Backpressure: none; free-running poll period of POLL_DIV cycles, pulses are fire-and-forget.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   DOUT[39:0]                packet from the SPI front end
//   SND_REC                   transaction request, high REQ_CYC cycles per poll
//   X_POS, Y_POS [9:0]        last sampled axis values
//   VALID                     high once the first sample has been taken
//   UP, DOWN, LEFT, RIGHT     one-cycle direction pulses (X and Y may coincide)
//   BTN_PRESS                 one-cycle pulse on a 0->1 button change between samples
// Optional feature: define JOY_AUTOREPEAT_EN for auto-repeat of held directions.
module joy_decoder
   import joy_pkg::*;
#(
   parameter int POLL_DIV = 1000000,
   parameter int REQ_CYC  = 2000,
   parameter int HI_THR   = DEF_HI_THR,
   parameter int LO_THR   = DEF_LO_THR,
   parameter int HYST     = DEF_HYST,
   parameter int REP_DLY  = 50,
   parameter int REP_RATE = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [39:0] DOUT,
   output logic        SND_REC,
   output logic [9:0]  X_POS,
   output logic [9:0]  Y_POS,
   output logic        VALID,
   output logic        UP,
   output logic        DOWN,
   output logic        LEFT,
   output logic        RIGHT,
   output logic        BTN_PRESS
);

   localparam int PW = $clog2(POLL_DIV);

   fsm_state_t    state;
   fsm_state_t    state_nxt;
   logic [PW-1:0] pcnt;
   logic          btn_hist;
   logic          sample_en;
   logic [9:0]    samp_x;
   logic [9:0]    samp_y;
   logic          samp_btn;

   assign sample_en = (state == ST_SAMPLE);
   assign samp_x    = get_x(DOUT);
   assign samp_y    = get_y(DOUT);
   assign samp_btn  = DOUT[BTN_BIT];

   // pcnt runs 0..POLL_DIV-1 across the whole poll; SAMPLE lands on the last count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_REQ;
         pcnt  <= '0;
      end else begin
         state <= state_nxt;
         pcnt  <= sample_en ? '0 : pcnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_REQ:    if (pcnt == PW'(REQ_CYC - 1))  state_nxt = ST_WAIT;
         ST_WAIT:   if (pcnt == PW'(POLL_DIV - 2)) state_nxt = ST_SAMPLE;
         ST_SAMPLE: state_nxt = ST_REQ;
         default:   state_nxt = ST_REQ;
      endcase
   end

   // VALID doubles as "history is primed": while low, the sample only initialises.
   always_ff @(posedge CLK) begin
      if (RST) begin
         SND_REC   <= 1'b0;
         X_POS     <= '0;
         Y_POS     <= '0;
         VALID     <= 1'b0;
         btn_hist  <= 1'b0;
         BTN_PRESS <= 1'b0;
      end else begin
         SND_REC   <= (state == ST_REQ);
         BTN_PRESS <= 1'b0;
         if (sample_en) begin
            X_POS     <= samp_x;
            Y_POS     <= samp_y;
            VALID     <= 1'b1;
            btn_hist  <= samp_btn;
            BTN_PRESS <= VALID && samp_btn && !btn_hist;
         end
      end
   end

   joy_axis #(
      .HI_THR  (HI_THR),
      .LO_THR  (LO_THR),
      .HYST    (HYST),
      .REP_DLY (REP_DLY),
      .REP_RATE(REP_RATE)
   ) u_axis_x (
      .CLK      (CLK),
      .RST      (RST),
      .sample_en(sample_en),
      .init     (!VALID),
      .val      (samp_x),
      .pos_pulse(RIGHT),
      .neg_pulse(LEFT)
   );

   joy_axis #(
      .HI_THR  (HI_THR),
      .LO_THR  (LO_THR),
      .HYST    (HYST),
      .REP_DLY (REP_DLY),
      .REP_RATE(REP_RATE)
   ) u_axis_y (
      .CLK      (CLK),
      .RST      (RST),
      .sample_en(sample_en),
      .init     (!VALID),
      .val      (samp_y),
      .pos_pulse(UP),
      .neg_pulse(DOWN)
   );

endmodule

// File: tb/tb_joy_decoder.sv
module tb_joy_decoder;

   localparam int POLL_DIV = 100;
   localparam int REQ_CYC  = 10;
   localparam int REP_DLY  = 3;
   localparam int REP_RATE = 2;
   localparam int HI_THR   = 700;
   localparam int LO_THR   = 324;
   localparam int HYST     = 32;

   logic        CLK = 1'b0;
   logic        RST;
   logic [39:0] DOUT;
   logic        SND_REC;
   logic [9:0]  X_POS;
   logic [9:0]  Y_POS;
   logic        VALID;
   logic        UP, DOWN, LEFT, RIGHT, BTN_PRESS;
   logic [4:0]  pl;

   assign pl = {UP, DOWN, LEFT, RIGHT, BTN_PRESS};

   always #5 CLK = ~CLK;

   joy_decoder #(
      .POLL_DIV(POLL_DIV), .REQ_CYC(REQ_CYC), .HI_THR(HI_THR), .LO_THR(LO_THR),
      .HYST(HYST), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)
   ) dut (
      .CLK(CLK), .RST(RST), .DOUT(DOUT), .SND_REC(SND_REC),
      .X_POS(X_POS), .Y_POS(Y_POS), .VALID(VALID),
      .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .RIGHT(RIGHT), .BTN_PRESS(BTN_PRESS)
   );

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [4:0] p;   // {UP, DOWN, LEFT, RIGHT, BTN_PRESS}
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   logic rst_q  = 1'b1;

   // reference model state: axis 0 = X, 1 = Y; state 0 centre, 1 positive, 2 negative
   int ax_st[2];
   int ax_held[2];
   bit m_btn;
   bit m_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_axis(input int ax, input int v, input bit init,
                                      output bit pp, output bit np);
      int  nxt;
      bit  fire;
      nxt  = ax_st[ax];
      fire = 1'b0;
      if (ax_st[ax] == 0) begin
         if (v > HI_THR) nxt = 1; else if (v < LO_THR) nxt = 2;
      end else if (ax_st[ax] == 1) begin
         if (v < LO_THR) nxt = 2; else if (v < HI_THR - HYST) nxt = 0;
      end else begin
         if (v > HI_THR) nxt = 1; else if (v > LO_THR + HYST) nxt = 0;
      end
      if (nxt != 0 && nxt != ax_st[ax]) begin
         ax_held[ax] = 0;
         fire = 1'b1;
      end else if (nxt != 0) begin
         ax_held[ax]++;
`ifdef JOY_AUTOREPEAT_EN
         if (ax_held[ax] == REP_DLY ||
             (ax_held[ax] > REP_DLY && (ax_held[ax] - REP_DLY) % REP_RATE == 0))
            fire = 1'b1;
`endif
      end else begin
         ax_held[ax] = 0;
      end
      ax_st[ax] = nxt;
      pp = fire && !init && nxt == 1;
      np = fire && !init && nxt == 2;
   endfunction

   task automatic model_reset();
      ax_st   = '{0, 0};
      ax_held = '{0, 0};
      m_btn   = 1'b0;
      m_valid = 1'b0;
      q.delete();
   endtask

   // Called at the negedge of the first cycle of a poll; DOUT is then stable
   // well before that poll's SAMPLE cycle. Returns one poll period later.
   task automatic do_sample(input int x, input int y, input bit b);
      logic [39:0] d;
      logic [9:0]  xv, yv;
      exp_t        e;
      bit          init, xp, xn, yp, yn, pr;
      xv = 10'(x);
      yv = 10'(y);
      d[31:0]  = $urandom();
      d[39:32] = 8'($urandom());
      d[39:32] = xv[7:0];
      d[25:24] = xv[9:8];
      d[23:16] = yv[7:0];
      d[9:8]   = yv[9:8];
      d[0]     = b;
      init = !m_valid;
      model_axis(0, x, init, xp, xn);
      model_axis(1, y, init, yp, yn);
      pr = !init && b && !m_btn;
      m_btn   = b;
      m_valid = 1'b1;
      e.x = xv;
      e.y = yv;
      e.p = {yp, yn, xn, xp, pr};
      q.push_back(e);
      DOUT = d;
      repeat (POLL_DIV) @(negedge CLK);
   endtask

   function automatic int pick();
      case ($urandom_range(0, 2))
         0:       return int'($urandom_range(0, 1023));
         1:       return HI_THR - 48 + int'($urandom_range(0, 96));
         default: return LO_THR - 48 + int'($urandom_range(0, 96));
      endcase
   endfunction

   // cycle 0 is the first cycle after the last edge that saw RST high
   always @(posedge CLK) begin
      rst_q <= RST;
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // monitor: every cycle checks request timing and idle pulses; on the first
   // cycle of each poll (one cycle after SAMPLE) pops and compares a result
   always @(negedge CLK) begin
      int   ph;
      exp_t e;
      if (rst_q) begin
         chk("rst_snd_rec", SND_REC, 0);
         chk("rst_valid", VALID, 0);
         chk("rst_x_pos", X_POS, 0);
         chk("rst_y_pos", Y_POS, 0);
         chk("rst_pulses", pl, 0);
      end else begin
         ph = cyc % POLL_DIV;
         chk("snd_rec", SND_REC, (ph >= 1 && ph <= REQ_CYC));
         chk("valid", VALID, (cyc >= POLL_DIV));
         if (ph == 0) begin
            if (q.size() == 0) begin
               chk("result_expected", 0, 1);
            end else begin
               e = q.pop_front();
               chk("x_pos", X_POS, e.x);
               chk("y_pos", Y_POS, e.y);
               chk("pulses", pl, e.p);
            end
         end else begin
            chk("idle_pulses", pl, 0);
         end
      end
   end

   initial begin
      RST  = 1'b1;
      DOUT = '0;
      model_reset();
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      do_sample(512, 512, 0);   // initialisation only
      do_sample(800, 512, 1);   // RIGHT, BTN_PRESS
      do_sample(680, 512, 1);   // stays POS
      do_sample(660, 512, 0);   // back to CENTER, no pulse
      do_sample(512, 512, 1);   // BTN_PRESS
      for (int i = 0; i < 8; i++) do_sample(1000, 10, 0);  // diagonal + repeats

      do_sample(512, 512, 0);
      do_sample(700, 324, 0);   // exactly on thresholds: CENTER
      do_sample(701, 323, 0);   // RIGHT + DOWN
      do_sample(668, 356, 0);   // on hysteresis edges: held
      do_sample(667, 357, 0);   // both leave to CENTER
      do_sample(1000, 0, 0);
      do_sample(0, 1023, 0);    // direct POS->NEG and NEG->POS

      for (int i = 0; i < 30; i++) do_sample(pick(), pick(), 1'($urandom_range(0, 1)));

      // reset in the middle of REQ
      repeat (5) @(negedge CLK);
      RST = 1'b1;
      model_reset();
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      do_sample(1000, 1000, 1); // initialisation only
      do_sample(1000, 1000, 1);
      do_sample(0, 0, 0);       // LEFT + DOWN

      repeat (2) @(negedge CLK);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
